// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and switch indices for the LED chaser sequencer.
package dance_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int unsigned SW_LEFT   = 0;
  localparam int unsigned SW_RIGHT  = 1;
  localparam int unsigned SW_BOUNCE = 2;
  localparam int unsigned SW_PAUSE  = 3;

  // Fixed-priority mode selection: left beats right beats bounce.
  function automatic mode_t arbitrate(input logic [3:0] req);
    if (req[SW_LEFT])   return MODE_LEFT;
    if (req[SW_RIGHT])  return MODE_RIGHT;
    if (req[SW_BOUNCE]) return MODE_BOUNCE;
    return MODE_IDLE;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Switch input and LED/status outputs of the chaser sequencer.
interface led_pattern_sequencer_if #(
  parameter int unsigned N_LEDS = 18
);
  import dance_pkg::*;

  localparam int unsigned POS_W = $clog2(N_LEDS);

  logic [17:0]       SW;
  logic [N_LEDS-1:0] led;
  logic [POS_W-1:0]  position;
  mode_t             mode;
  logic              tick;

  modport master (output SW, input led, position, mode, tick);
  modport slave  (input SW, output led, position, mode, tick);

endinterface

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// Modulo-TICK_DIV step prescaler.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 33554432
) (
  input  logic Clock,
  input  logic Reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] cnt;

  // tick is registered one count early so it is high exactly while cnt == TICK_DIV-1,
  // letting the consumer act on the same edge where the count wraps.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// 18-LED chaser: switch synchronizer, mode arbiter and pattern state machine.
module led_pattern_sequencer
  import dance_pkg::*;
#(
  parameter int unsigned N_LEDS   = 18,
  parameter int unsigned TICK_DIV = 33554432
) (
  input logic                    Clock,
  input logic                    Reset,
  led_pattern_sequencer_if.slave bus
);

  localparam int unsigned POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);

  logic [3:0]        sync1;
  logic [3:0]        req;
  logic              step_due;
  logic              step;
  logic              tick_q;
  mode_t             mode_q, nxt_mode, want;
  dir_t              dir_q, nxt_dir;
  logic [POS_W-1:0]  pos_q, nxt_pos;
  logic [N_LEDS-1:0] led_q, nxt_led;
  logic              unused_sw;

  assign unused_sw = ^bus.SW[17:4];

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .Clock (Clock),
    .Reset (Reset),
    .tick  (step_due)
  );

  assign step = step_due & ~req[SW_PAUSE];
  assign want = arbitrate(req);

  always_comb begin
    nxt_mode = mode_q;
    nxt_pos  = pos_q;
    nxt_dir  = dir_q;
    if (want != mode_q) begin
      nxt_mode = want;
      nxt_pos  = '0;
      if (want == MODE_RIGHT)  nxt_pos = LAST;
      if (want == MODE_BOUNCE) nxt_dir = DIR_UP;
    end else begin
      case (mode_q)
        MODE_LEFT:  nxt_pos = (pos_q == LAST) ? '0 : pos_q + ONE;
        MODE_RIGHT: nxt_pos = (pos_q == '0) ? LAST : pos_q - ONE;
        MODE_BOUNCE: begin
          // Reverse on reaching an end so each endpoint is shown for one step only.
          if (dir_q == DIR_UP) begin
            if (pos_q == LAST) begin
              nxt_pos = LAST - ONE;
              nxt_dir = DIR_DOWN;
            end else begin
              nxt_pos = pos_q + ONE;
            end
          end else begin
            if (pos_q == '0) begin
              nxt_pos = ONE;
              nxt_dir = DIR_UP;
            end else begin
              nxt_pos = pos_q - ONE;
            end
          end
        end
        default: nxt_pos = pos_q;
      endcase
    end
    nxt_led = (nxt_mode == MODE_IDLE) ? '0 : (N_LEDS'(1) << nxt_pos);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1  <= '0;
      req    <= '0;
      tick_q <= 1'b0;
      mode_q <= MODE_IDLE;
      dir_q  <= DIR_UP;
      pos_q  <= '0;
      led_q  <= '0;
    end else begin
      sync1  <= bus.SW[3:0];
      req    <= sync1;
      tick_q <= step_due;
      if (step) begin
        mode_q <= nxt_mode;
        dir_q  <= nxt_dir;
        pos_q  <= nxt_pos;
        led_q  <= nxt_led;
      end
    end
  end

  assign bus.led      = led_q;
  assign bus.position = pos_q;
  assign bus.mode     = mode_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer with N_LEDS=18, TICK_DIV=4.
module tb_led_pattern_sequencer;
  import dance_pkg::*;

  localparam int N   = 18;
  localparam int DIV = 4;

  typedef struct {
    int mode;
    int pos;
    int led;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  led_pattern_sequencer_if #(.N_LEDS(N)) bus ();

  led_pattern_sequencer #(.N_LEDS(N), .TICK_DIV(DIV)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: bounce is tracked as a phase around a 2*(N-1) cycle.
  int          m_cyc   = 0;
  int          m_mode  = 0;
  int          m_pos   = 0;
  int          m_phase = 0;
  logic [17:0] hist[$];
  exp_t        expq[$];

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int led_of(input int mode, input int pos);
    return (mode == 0) ? 0 : (1 << pos);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_mode = 0; m_pos = 0; m_phase = 0;
    hist.delete();
    expq.delete();
  endtask

  always @(posedge Clock) begin
    if (!Reset) begin
      logic [17:0] req;
      int want;
      exp_t e;
      m_cyc++;
      req = (hist.size() >= 2) ? hist[1] : 18'd0;
      hist.push_front(bus.SW);
      if (hist.size() > 4) void'(hist.pop_back());
      if (m_cyc % DIV == 0) begin
        if (!req[3]) begin
          want = req[0] ? 1 : req[1] ? 2 : req[2] ? 3 : 0;
          if (want != m_mode) begin
            m_mode  = want;
            m_phase = 0;
            m_pos   = (want == 2) ? N - 1 : 0;
          end else if (m_mode == 1) begin
            m_pos = (m_pos + 1) % N;
          end else if (m_mode == 2) begin
            m_pos = (m_pos + N - 1) % N;
          end else if (m_mode == 3) begin
            m_phase = (m_phase + 1) % (2 * N - 2);
            m_pos   = (m_phase < N) ? m_phase : (2 * N - 2 - m_phase);
          end
        end
        e.mode = m_mode;
        e.pos  = m_pos;
        e.led  = led_of(m_mode, m_pos);
        expq.push_back(e);
      end
    end
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      exp_t e;
      if (bus.tick) begin
        if (expq.size() == 0) begin
          check("tick_unexpected", 1, 0);
        end else begin
          e = expq.pop_front();
          check("mode", int'(bus.mode), e.mode);
          check("position", int'(bus.position), e.pos);
          check("led", int'(bus.led), e.led);
        end
      end else if (expq.size() != 0) begin
        check("tick_missing", 0, 1);
        expq.delete();
      end
      check("led_matches_position", int'(bus.led), led_of(int'(bus.mode), int'(bus.position)));
    end
  end

  task automatic drive(input logic [17:0] sw, input int cycles);
    @(negedge Clock);
    bus.SW = sw;
    repeat (cycles) @(negedge Clock);
  endtask

  initial begin
    logic [17:0] sw;
    int guard;

    bus.SW = '0;
    model_reset();
    #1;
    check("reset_led", int'(bus.led), 0);
    check("reset_position", int'(bus.position), 0);
    check("reset_mode", int'(bus.mode), 0);
    check("reset_tick", int'(bus.tick), 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    drive(18'h0, 10 * DIV);
    drive(18'h1, 22 * DIV);
    drive(18'h2, 22 * DIV);
    drive(18'h4, 40 * DIV);
    drive(18'h7, 3 * DIV + 1);
    drive(18'h6, 3 * DIV);

    // Re-enter bounce, then pause while it sits at position 9.
    drive(18'h4, 1);
    guard = 0;
    while (!(m_mode == 3 && m_pos == 9) && guard < 300) begin
      @(negedge Clock);
      guard++;
    end
    if (guard >= 300) check("reach_bounce_9_timeout", guard, 0);
    bus.SW = 18'hC;
    repeat (3 * DIV) @(negedge Clock);
    check("paused_position", int'(bus.position), 9);
    drive(18'h4, 10 * DIV);

    for (int i = 0; i < 150; i++) begin
      sw = 18'($urandom);
      if ($urandom_range(0, 3) != 0) sw[3] = 1'b0;
      drive(sw, $urandom_range(1, 12));
    end

    // Asynchronous reset in the middle of a clock period.
    drive(18'h1, 6 * DIV);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_led", int'(bus.led), 0);
    check("async_reset_position", int'(bus.position), 0);
    check("async_reset_mode", int'(bus.mode), 0);
    check("async_reset_tick", int'(bus.tick), 0);
    bus.SW = 18'h4;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (12 * DIV) @(negedge Clock);
    drive(18'h0, 3 * DIV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Sequencer for the 18-LED chaser on the board. It selects one of three patterns from the slide switches: shift left, shift right, or bounce. A prescaler paces the pattern. The block owns the one-hot LED register and the position and direction state. It sits between the switch bank and the LED pins and replaces free-running per-pattern logic with one arbitrated state machine.

## Interface
- N_LEDS, 18, number of LEDs in the chain (≥2).
- TICK_DIV, 33554432, Clock cycles per pattern step (≥2); counter width is $clog2(TICK_DIV).
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- SW  in  18  slide switches. SW[0] = left, SW[1] = right, SW[2] = bounce, SW[3] = pause. SW[17:4] are ignored.
- led  out  N_LEDS  one-hot pattern (all-zero in IDLE), registered.
- position  out  $clog2(N_LEDS)  index of the lit LED, registered.
- mode  out  2  current mode (mode_t), registered.
- tick  out  1  one-cycle pulse coincident with each led update opportunity.

## Operation
- Input sync: SW[3:0] pass through a 2-flop synchronizer. All decisions use the synchronized value (req).
- Mode arbitration, fixed priority:
  - req[0] selects LEFT.
  - Otherwise req[1] selects RIGHT.
  - Otherwise req[2] selects BOUNCE.
  - Otherwise IDLE.
- The requested mode is evaluated only on a step edge, defined below. Switch changes between steps have no effect.
- Step edge: the prescaler count equals TICK_DIV-1 and req[3] (pause) is 0.
- Prescaler behaviour:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - It keeps counting during pause.
  - It does not stop in IDLE.
- At a step edge, if the requested mode differs from mode, the block enters the new mode:
  - LEFT: position = 0.
  - RIGHT: position = N_LEDS-1.
  - BOUNCE: position = 0, dir = up.
  - IDLE: position = 0, led = 0.
  - In every non-IDLE mode, led = onehot(position).
- At a step edge with the mode unchanged, the block advances:
  - LEFT: position = (position == N_LEDS-1) ? 0 : position+1.
  - RIGHT: position = (position == 0) ? N_LEDS-1 : position-1.
  - BOUNCE: move one step in dir. At N_LEDS-1, dir flips to down and the next step goes to N_LEDS-2. At 0, dir flips to up. Each endpoint is shown for exactly one step.
  - IDLE: no change.
- Exactly one led bit is set in every non-IDLE mode, at all times.
- Pause freezes mode, position, dir and led. Mode changes requested during pause apply at the first step edge after pause is released.
- Reset values: led = 0, position = 0, mode = IDLE, dir = up, tick = 0, prescaler = 0, synchronizer = 0.
- Reset mid-pattern returns to these values asynchronously. After release, the first step occurs TICK_DIV cycles later.

## Timing
- led, position, mode and the tick pulse all update on the same posedge, the one where the prescaler count is TICK_DIV-1.
- tick is high for exactly one cycle every TICK_DIV cycles and is independent of pause and mode.
- Switch-to-effect latency: 2 cycles of synchronization, then wait for the next step edge. Worst case is 2+TICK_DIV cycles.
- A switch change that reaches the synchronizer output in the cycle of a step edge applies at that edge. A change one cycle later waits a full period.
- No combinational path from SW to any output.

## Structure
- Package dance_pkg holds:
  - mode_t, 2-bit enum: MODE_IDLE = 0, MODE_LEFT = 1, MODE_RIGHT = 2, MODE_BOUNCE = 3.
  - dir_t: DIR_UP = 0, DIR_DOWN = 1.
  - Switch index constants: SW_LEFT = 0, SW_RIGHT = 1, SW_BOUNCE = 2, SW_PAUSE = 3.
- Sub-module tick_prescaler holds the modulo-TICK_DIV counter and the registered tick output. Its parameter is TICK_DIV; its ports are Clock, Reset and tick.
- The top module contains the synchronizer, the arbiter and the sequencer FSM (state = mode + dir + position).

## Test plan
All scenarios use N_LEDS = 18 and TICK_DIV = 4.
- Reset then SW = 0: led = 0 and mode = IDLE forever. tick pulses every 4 cycles, the first one 4 cycles after Reset deasserts.
- SW = 18'h1: the first step edge gives led = 18'h00001. Position then runs 1..17 on later ticks, then wraps to 0 (led = 18'h00001) on the 19th step.
- SW = 18'h2: led starts at 18'h20000 and decrements. After position 0 it wraps to 17.
- SW = 18'h4: the position sequence is 0,1,…,17,16,…,1,0,1. Each endpoint is held for one tick, and led is one-hot throughout.
- SW = 18'h7: mode = LEFT (priority). Then drop SW[0] mid-period: RIGHT is entered at the next step with position = 17, not earlier.
- BOUNCE at position 9, assert SW[3] for 3 periods: led, position and dir are frozen while tick keeps pulsing. After release, motion resumes from 9. Asserting Reset mid-run clears led to 0 in the same cycle, without waiting for a clock edge.
